// File: rtl/pcs_sync_param.sv
// rtl/pcs_sync_param.sv - 1000BASE-X PCS receive code-group synchronisation with configurable thresholds
//
// Comma-acquisition / loss-of-sync state machine for 10-bit code-groups.
// Optional statistics counters are built only when SYNC_STATS_EN is defined;
// otherwise loss_count and invalid_count are tied to zero.
//
// Parameters:
//   COMMA_REQ      even-aligned commas (each followed by a valid non-comma) to gain sync, 1..15
//   BAD_MAX        net bad code-groups that drop sync, 1..15
//   GOOD_REQ       consecutive good code-groups that cancel one bad count, 1..15
//   CNT_W          statistics counter width
// Ports:
//   Clk              rising-edge clock
//   mr_main_reset    synchronous active-high reset
//   power_on         0 forces LOSS_OF_SYNC and clears the acquisition counters
//   PUDI[9:0]        code-group, PUDI[9] is bit a
//   PUDI_indicate    PUDI valid this cycle
//   code_sync_status 1 while in SYNC_ACQUIRED
//   SUDI[10:0]       {rx_even, PUDI} of the last processed group
//   SUDI_indicate    one-cycle pulse when SUDI updates
//   loss_count       saturating count of sync-loss events
//   invalid_count    saturating count of invalid groups seen in sync

module pcs_sync_param #(
    parameter int COMMA_REQ = 3,
    parameter int BAD_MAX   = 4,
    parameter int GOOD_REQ  = 4,
    parameter int CNT_W     = 8
) (
    input  logic             Clk,
    input  logic             mr_main_reset,
    input  logic             power_on,
    input  logic [9:0]       PUDI,
    input  logic             PUDI_indicate,
    output logic             code_sync_status,
    output logic [10:0]      SUDI,
    output logic             SUDI_indicate,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] invalid_count
);

    localparam logic [3:0] COMMA_REQ_C = 4'(COMMA_REQ);
    localparam logic [3:0] BAD_MAX_C   = 4'(BAD_MAX);
    localparam logic [3:0] GOOD_REQ_C  = 4'(GOOD_REQ);

    typedef enum logic [1:0] {
        LOSS_OF_SYNC,
        COMMA_DETECT,
        ACQUIRE_SYNC,
        SYNC_ACQUIRED
    } sync_state_t;

    sync_state_t state;
    logic        rx_even;
    logic [3:0]  comma_cnt;
    logic [3:0]  bad_cnt;
    logic [3:0]  good_cnt;

    // Disparity-legal weight and no run longer than five: any six-bit window
    // that is all-equal marks the group invalid.
    function automatic logic group_valid(input logic [9:0] g);
        int   ones;
        logic long_run;
        ones     = 0;
        long_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ones = ones + {31'b0, g[i]};
        end
        for (int i = 0; i < 5; i++) begin
            if (g[i +: 6] == 6'b000000 || g[i +: 6] == 6'b111111) begin
                long_run = 1'b1;
            end
        end
        return (ones >= 4) && (ones <= 6) && !long_run;
    endfunction

    logic valid;
    logic comma;
    logic is_bad;
    logic bad_hit;
    logic rx_even_next;

    assign valid   = group_valid(PUDI);
    assign comma   = valid && (PUDI[9:3] == 7'b0011111 || PUDI[9:3] == 7'b1100000);
    // In sync, a comma landing on an odd position counts as a bad group.
    assign is_bad  = !valid || (comma && rx_even);
    assign bad_hit = (bad_cnt + 4'd1) == BAD_MAX_C;

    // Every processed group toggles rx_even; the only forced value that the
    // toggle does not already produce is the first comma out of LOSS_OF_SYNC.
    assign rx_even_next = (power_on && state == LOSS_OF_SYNC && comma) ? 1'b1 : !rx_even;

    always_ff @(posedge Clk) begin
        if (mr_main_reset) begin
            state            <= LOSS_OF_SYNC;
            code_sync_status <= 1'b0;
            SUDI             <= '0;
            SUDI_indicate    <= 1'b0;
            rx_even          <= 1'b0;
            comma_cnt        <= '0;
            bad_cnt          <= '0;
            good_cnt         <= '0;
        end else begin
            SUDI_indicate <= PUDI_indicate;
            if (PUDI_indicate) begin
                rx_even <= rx_even_next;
                SUDI    <= {rx_even_next, PUDI};
            end

            if (!power_on) begin
                state            <= LOSS_OF_SYNC;
                code_sync_status <= 1'b0;
                comma_cnt        <= '0;
                bad_cnt          <= '0;
                good_cnt         <= '0;
            end else if (PUDI_indicate) begin
                case (state)
                    LOSS_OF_SYNC: begin
                        if (comma) begin
                            state     <= COMMA_DETECT;
                            comma_cnt <= 4'd1;
                        end
                    end
                    COMMA_DETECT: begin
                        if (valid && !comma) begin
                            if (comma_cnt == COMMA_REQ_C) begin
                                state            <= SYNC_ACQUIRED;
                                code_sync_status <= 1'b1;
                                bad_cnt          <= '0;
                                good_cnt         <= '0;
                            end else begin
                                state <= ACQUIRE_SYNC;
                            end
                        end else begin
                            state <= LOSS_OF_SYNC;
                        end
                    end
                    ACQUIRE_SYNC: begin
                        if (comma && !rx_even) begin
                            state     <= COMMA_DETECT;
                            comma_cnt <= comma_cnt + 4'd1;
                        end else if (comma || !valid) begin
                            state <= LOSS_OF_SYNC;
                        end
                    end
                    SYNC_ACQUIRED: begin
                        if (is_bad) begin
                            bad_cnt  <= bad_cnt + 4'd1;
                            good_cnt <= '0;
                            if (bad_hit) begin
                                state            <= LOSS_OF_SYNC;
                                code_sync_status <= 1'b0;
                            end
                        end else if (bad_cnt != 4'd0) begin
                            if ((good_cnt + 4'd1) == GOOD_REQ_C) begin
                                bad_cnt  <= bad_cnt - 4'd1;
                                good_cnt <= '0;
                            end else begin
                                good_cnt <= good_cnt + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state            <= LOSS_OF_SYNC;
                        code_sync_status <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SYNC_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic processing;
    logic loss_event;
    logic invalid_event;

    assign processing    = power_on && PUDI_indicate && (state == SYNC_ACQUIRED);
    assign loss_event    = processing && is_bad && bad_hit;
    assign invalid_event = processing && !valid;

    always_ff @(posedge Clk) begin
        if (mr_main_reset) begin
            loss_count    <= '0;
            invalid_count <= '0;
        end else begin
            if (loss_event && loss_count != '1) begin
                loss_count <= loss_count + CNT_ONE;
            end
            if (invalid_event && invalid_count != '1) begin
                invalid_count <= invalid_count + CNT_ONE;
            end
        end
    end
`else
    assign loss_count    = '0;
    assign invalid_count = '0;
`endif

endmodule

// File: tb/tb_pcs_sync_param.sv
// tb/tb_pcs_sync_param.sv - randomized self-checking bench for pcs_sync_param

module tb_pcs_sync_param;

    localparam int COMMA_REQ = 3;
    localparam int BAD_MAX   = 4;
    localparam int GOOD_REQ  = 4;
    localparam int CNT_W     = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    localparam logic [9:0] K_POS = 10'b0011111010;
    localparam logic [9:0] K_NEG = 10'b1100000101;
    localparam logic [9:0] D16_2 = 10'b0110110101;
    localparam logic [9:0] D21_5 = 10'b1010101010;
    localparam logic [9:0] ZERO  = 10'b0000000000;

    logic             Clk = 1'b0;
    logic             mr_main_reset;
    logic             power_on;
    logic [9:0]       PUDI;
    logic             PUDI_indicate;
    logic             code_sync_status;
    logic [10:0]      SUDI;
    logic             SUDI_indicate;
    logic [CNT_W-1:0] loss_count;
    logic [CNT_W-1:0] invalid_count;

    int n_vec = 0;
    int n_err = 0;

    pcs_sync_param #(
        .COMMA_REQ(COMMA_REQ),
        .BAD_MAX  (BAD_MAX),
        .GOOD_REQ (GOOD_REQ),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk             (Clk),
        .mr_main_reset   (mr_main_reset),
        .power_on        (power_on),
        .PUDI            (PUDI),
        .PUDI_indicate   (PUDI_indicate),
        .code_sync_status(code_sync_status),
        .SUDI            (SUDI),
        .SUDI_indicate   (SUDI_indicate),
        .loss_count      (loss_count),
        .invalid_count   (invalid_count)
    );

    always #5 Clk = ~Clk;

    // Reference model: phase 0 hunting, 1 just saw an aligned comma,
    // 2 acquiring, 3 locked.
    int          m_phase;
    bit          m_even;
    int          m_commas;
    int          m_bad;
    int          m_good;
    int          m_loss;
    int          m_inv;
    bit          m_status;
    logic [10:0] m_sudi;
    bit          m_ind;

    function automatic bit is_valid(input logic [9:0] g);
        int run;
        int longest;
        run     = 1;
        longest = 1;
        for (int i = 1; i < 10; i++) begin
            run = (g[i] == g[i-1]) ? run + 1 : 1;
            if (run > longest) longest = run;
        end
        return ($countones(g) >= 4) && ($countones(g) <= 6) && (longest <= 5);
    endfunction

    function automatic bit is_comma(input logic [9:0] g);
        logic [6:0] head;
        head = g[9:3];
        return is_valid(g) && (head == 7'b0011111 || head == 7'b1100000);
    endfunction

    task automatic model(input logic rst, input logic pwr, input logic [9:0] g, input logic ind);
        bit c;
        bit v;
        bit was_even;
        if (rst) begin
            m_phase = 0; m_even = 0; m_commas = 0; m_bad = 0; m_good = 0;
            m_loss = 0; m_inv = 0; m_status = 0; m_sudi = '0; m_ind = 0;
            return;
        end
        m_ind = ind;
        if (!pwr) begin
            m_phase = 0; m_commas = 0; m_bad = 0; m_good = 0; m_status = 0;
            if (ind) begin
                m_even = !m_even;
                m_sudi = {m_even, g};
            end
            return;
        end
        if (!ind) return;
        c        = is_comma(g);
        v        = is_valid(g);
        was_even = m_even;
        m_even   = !m_even;
        case (m_phase)
            0: if (c) begin m_phase = 1; m_commas = 1; m_even = 1; end
            1: begin
                if (v && !c) m_phase = (m_commas == COMMA_REQ) ? 3 : 2;
                else         m_phase = 0;
                if (m_phase == 3) begin m_bad = 0; m_good = 0; end
            end
            2: begin
                if (c && !was_even) begin m_phase = 1; m_commas++; m_even = 1; end
                else if (c || !v)   m_phase = 0;
            end
            default: begin
                if (!v || (c && was_even)) begin
                    m_bad++;
                    m_good = 0;
                    if (!v && m_inv < CNT_MAX) m_inv++;
                    if (m_bad == BAD_MAX) begin
                        m_phase = 0;
                        if (m_loss < CNT_MAX) m_loss++;
                    end
                end else if (m_bad > 0) begin
                    m_good++;
                    if (m_good == GOOD_REQ) begin m_bad--; m_good = 0; end
                end
            end
        endcase
        m_sudi   = {m_even, g};
        m_status = (m_phase == 3);
    endtask

    function automatic int exp_loss();
`ifdef SYNC_STATS_EN
        return m_loss;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_inv();
`ifdef SYNC_STATS_EN
        return m_inv;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic pwr, input logic [9:0] g, input logic ind);
        mr_main_reset = rst;
        power_on      = pwr;
        PUDI          = g;
        PUDI_indicate = ind;
        model(rst, pwr, g, ind);
        @(posedge Clk);
        #1;
        chk("code_sync_status", 32'(code_sync_status), 32'(m_status));
        chk("SUDI",             32'(SUDI),             32'(m_sudi));
        chk("SUDI_indicate",    32'(SUDI_indicate),    32'(m_ind));
        chk("loss_count",       32'(loss_count),       32'(exp_loss()));
        chk("invalid_count",    32'(invalid_count),    32'(exp_inv()));
    endtask

    task automatic send(input logic [9:0] g);
        step(1'b0, 1'b1, g, 1'b1);
    endtask

    task automatic acquire();
        for (int i = 0; i < COMMA_REQ; i++) begin
            send(K_POS);
            send(D16_2);
        end
        chk("acquired", 32'(code_sync_status), 32'd1);
    endtask

    initial begin
        logic [9:0] g;
        int         sel;

        step(1'b1, 1'b1, 10'($urandom), 1'b1);
        step(1'b1, 1'b1, 10'($urandom), 1'b0);
        chk("reset_status", 32'(code_sync_status), 32'd0);
        chk("reset_sudi",   32'(SUDI),             32'd0);

        // Acquisition with SUDI[10] alternating 1,0.
        for (int i = 0; i < COMMA_REQ; i++) begin
            send(K_POS);
            chk("even_after_comma", 32'(SUDI[10]), 32'd1);
            send(D16_2);
            chk("even_after_data", 32'(SUDI[10]), 32'd0);
        end
        chk("sync_after_6", 32'(code_sync_status), 32'd1);

        // Four invalids interleaved with data lose sync.
        for (int i = 0; i < 4; i++) begin
            send(ZERO);
            if (i < 3) send(D16_2);
        end
        chk("loss_by_invalid", 32'(code_sync_status), 32'd0);

        // Good-run recovery of one bad count keeps sync until the fourth net bad.
        acquire();
        send(ZERO);
        for (int i = 0; i < GOOD_REQ; i++) send(D16_2);
        for (int i = 0; i < 3; i++) send(ZERO);
        chk("still_sync_bad3", 32'(code_sync_status), 32'd1);
        send(ZERO);
        chk("lost_after_net4", 32'(code_sync_status), 32'd0);

        // Commas on odd positions in sync.
        acquire();
        send(K_POS);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) send(D16_2);
            send(K_POS);
        end
        chk("loss_by_odd_comma", 32'(code_sync_status), 32'd0);

        // Misaligned comma during acquisition, then a clean re-acquisition.
        send(K_NEG);
        send(D16_2);
        send(D21_5);
        send(K_POS);
        chk("acq_odd_comma_lost", 32'(code_sync_status), 32'd0);
        acquire();

        // power_on low mid-sync keeps statistics, then reset clears everything.
        step(1'b0, 1'b0, D16_2, 1'b1);
        chk("power_off_status", 32'(code_sync_status), 32'd0);
        step(1'b0, 1'b1, K_POS, 1'b0);
        acquire();
        step(1'b1, 1'b1, D16_2, 1'b1);
        chk("reset_mid_sync", 32'(code_sync_status), 32'd0);

        // Randomized traffic, biased toward aligned K/D so sync is reached often.
        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 65)      g = m_even ? D16_2 : (($urandom_range(0, 1) == 0) ? K_POS : K_NEG);
            else if (sel < 72) g = K_POS;
            else if (sel < 80) g = D21_5;
            else if (sel < 86) g = ZERO;
            else               g = 10'($urandom);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) != 0), g,
                 ($urandom_range(0, 9) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
